// File: rtl/bht_scheduler_pkg.sv
// Shared constants for the branch history table scheduler.
//   - 2-bit counter encodings and the value the table is cleared to
//   - sweep FSM state codes
//   - ctr_next(): saturating counter update
package bht_scheduler_pkg;

  localparam logic [1:0] BHT_SNT     = 2'd0;  // strongly not-taken
  localparam logic [1:0] BHT_WNT     = 2'd1;  // weakly not-taken
  localparam logic [1:0] BHT_WT      = 2'd2;  // weakly taken
  localparam logic [1:0] BHT_ST      = 2'd3;  // strongly taken
  localparam logic [1:0] BHT_RST_VAL = BHT_WNT;

  typedef enum logic {
    BHT_INIT = 1'b0,
    BHT_RUN  = 1'b1
  } bht_state_e;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == BHT_ST)  ? BHT_ST  : ctr + 2'd1;
    else       return (ctr == BHT_SNT) ? BHT_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bht_scheduler_if.sv
// Fetch/RS-facing bus of the BHT scheduler.
//   master : Fetcher + RS side (drives lookup and training requests)
//   slave  : bht_scheduler
//   Lookup  : Fetcher_Ready, PC -> Predict_Valid, Predict_Taken, Lookup_Stall
//   Training: Train_Ready, Train_PC, Train_Result -> Train_Full
//   Status  : Init_Busy
interface bht_scheduler_if;
  logic        Fetcher_Ready;
  logic [31:0] PC;
  logic        Predict_Valid;
  logic        Predict_Taken;
  logic        Lookup_Stall;
  logic        Train_Ready;
  logic [31:0] Train_PC;
  logic        Train_Result;
  logic        Train_Full;
  logic        Init_Busy;

  modport master (
    output Fetcher_Ready, PC, Train_Ready, Train_PC, Train_Result,
    input  Predict_Valid, Predict_Taken, Lookup_Stall, Train_Full, Init_Busy
  );

  modport slave (
    input  Fetcher_Ready, PC, Train_Ready, Train_PC, Train_Result,
    output Predict_Valid, Predict_Taken, Lookup_Stall, Train_Full, Init_Busy
  );
endinterface

// File: rtl/bht_scheduler_train_fifo.sv
// bht_train_fifo: circular training queue with wrap-bit pointers.
//   clk, rst  : clock, synchronous active-low reset
//   i_push    : enqueue request (refused while o_full, even if popping)
//   i_data    : entry to enqueue
//   i_pop     : dequeue head (ignored when empty)
//   o_data    : head entry
//   o_count   : occupancy, derived from registered pointers only, so an
//               entry pushed in cycle N is visible at the head from N+1
//   o_full    : o_count == DEPTH
// Callers freeze the queue by not pushing/popping; no enable port needed.
module bht_train_fifo #(
  parameter int DEPTH = 4,   // power of 2, >= 2
  parameter int DW    = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [DW-1:0]            i_data,
  input  logic                     i_pop,
  output logic [DW-1:0]            o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   r_wptr, r_rptr;
  logic [DW-1:0] r_mem [DEPTH];
  logic          w_push, w_pop;

  assign o_count = r_wptr - r_rptr;
  assign o_full  = (o_count == (AW+1)'(DEPTH));
  assign o_data  = r_mem[r_rptr[AW-1:0]];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && (o_count != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/bht_scheduler.sv
// bht_scheduler: branch history table of 2-bit saturating counters with a
// single access slot per cycle shared between fetch lookups and training
// updates drained from a small queue.
//   clk  : clock
//   rst  : synchronous active-low reset; restarts the clear sweep, empties queue
//   rdy  : global enable; when low every register holds
//   bus  : bht_scheduler_if.slave (lookup, training, status signals)
// Optional feature macro: PRED_GSHARE_EN -- XOR table index with a global
// history register shifted by each applied update.
module bht_scheduler
  import bht_scheduler_pkg::*;
#(
  parameter int IDX_W        = 8,
  parameter int TQ_DEPTH     = 4,
  parameter int STARVE_LIMIT = 3   // >= 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  bht_scheduler_if.slave bus
);
  localparam int ENTRIES = 1 << IDX_W;
  localparam int SW      = $clog2(STARVE_LIMIT + 1);
  localparam int QCW     = $clog2(TQ_DEPTH) + 1;

  bht_state_e       r_state;
  logic [IDX_W-1:0] r_init_idx;
  logic [SW-1:0]    r_starve;
  logic             r_pred_valid;
  logic             r_pred_taken;
  logic [1:0]       r_bht [ENTRIES];

  logic [IDX_W-1:0] w_ghr;
  logic [IDX_W-1:0] w_lk_idx, w_upd_idx, w_q_pc_idx;
  logic             w_q_res;
  logic [IDX_W:0]   w_q_data;
  logic [QCW-1:0]   w_q_count;
  logic             w_q_full, w_q_nonempty;
  logic             w_run, w_force, w_accept;
  logic             w_we;
  logic [IDX_W-1:0] w_waddr;
  logic [1:0]       w_wdata;
  logic             w_unused_pc;

`ifdef PRED_GSHARE_EN
  logic [IDX_W-1:0] r_ghr;
  assign w_ghr = r_ghr;
`else
  assign w_ghr = '0;
`endif

  // Only the index bits of each PC matter.
  assign w_unused_pc = ^{bus.PC[31:IDX_W+2], bus.PC[1:0],
                         bus.Train_PC[31:IDX_W+2], bus.Train_PC[1:0]};

  // Queue entries carry the index bits and direction; the history XOR is
  // applied at update time with the history current then.
  bht_train_fifo #(.DEPTH(TQ_DEPTH), .DW(IDX_W + 1)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (rdy && bus.Train_Ready),
    .i_data  ({bus.Train_PC[IDX_W+1:2], bus.Train_Result}),
    .i_pop   (rdy && w_force),
    .o_data  (w_q_data),
    .o_count (w_q_count),
    .o_full  (w_q_full)
  );

  assign w_q_pc_idx   = w_q_data[IDX_W:1];
  assign w_q_res      = w_q_data[0];
  assign w_q_nonempty = (w_q_count != '0);

  assign w_lk_idx  = bus.PC[IDX_W+1:2] ^ w_ghr;
  assign w_upd_idx = w_q_pc_idx ^ w_ghr;

  // An update takes the slot when fetch is idle or fetch has won
  // STARVE_LIMIT cycles in a row while the queue was waiting.
  assign w_run    = (r_state == BHT_RUN);
  assign w_force  = w_run && w_q_nonempty &&
                    (!bus.Fetcher_Ready || (r_starve == SW'(STARVE_LIMIT)));
  assign w_accept = w_run && bus.Fetcher_Ready && !w_force;

  // Stall also while rdy is low: nothing is accepted in a frozen cycle.
  assign bus.Lookup_Stall  = !rdy || !w_run || (bus.Fetcher_Ready && w_force);
  assign bus.Predict_Valid = r_pred_valid;
  assign bus.Predict_Taken = r_pred_taken;
  assign bus.Train_Full    = w_q_full;
  assign bus.Init_Busy     = !w_run;

  // Single table write port: sweep clear or training update.
  assign w_we    = !w_run || w_force;
  assign w_waddr = w_run ? w_upd_idx : r_init_idx;
  assign w_wdata = w_run ? ctr_next(r_bht[w_upd_idx], w_q_res) : BHT_RST_VAL;

  always_ff @(posedge clk) begin
    if (rst && rdy && w_we) r_bht[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= BHT_INIT;
      r_init_idx   <= '0;
      r_starve     <= '0;
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
`ifdef PRED_GSHARE_EN
      r_ghr        <= '0;
`endif
    end else if (rdy) begin
      case (r_state)
        BHT_INIT: begin
          r_pred_valid <= 1'b0;
          r_init_idx   <= r_init_idx + 1'b1;
          if (r_init_idx == '1) r_state <= BHT_RUN;
        end
        BHT_RUN: begin
          r_pred_valid <= w_accept;
          if (w_accept) r_pred_taken <= r_bht[w_lk_idx][1];
          // Count only lookups that beat a waiting update.
          if (w_accept && w_q_nonempty) r_starve <= r_starve + 1'b1;
          else                          r_starve <= '0;
`ifdef PRED_GSHARE_EN
          if (w_force) r_ghr <= {r_ghr[IDX_W-2:0], w_q_res};
`endif
        end
        default: r_state <= BHT_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_bht_scheduler.sv
// Self-checking bench for bht_scheduler. A behavioural model (counter array,
// entry queue, starvation count, remaining-sweep count) is stepped with the
// same inputs each cycle; directed scenarios and a randomized run compare
// DUT outputs against it.
module tb_bht_scheduler;
  localparam int IDX_W        = 8;
  localparam int TQ_DEPTH     = 4;
  localparam int STARVE_LIMIT = 3;
  localparam int ENTRIES      = 1 << IDX_W;
  localparam int IMASK        = ENTRIES - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;
  always #5 clk = ~clk;

  bht_scheduler_if bus();

  bht_scheduler #(.IDX_W(IDX_W), .TQ_DEPTH(TQ_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  typedef struct { int idx; bit tk; } tent_t;
  int    m_ctr [ENTRIES];
  tent_t m_q [$];
  int    m_starve;
  int    m_init_left;
  bit    m_pv, m_pt;
  int    m_ghr;
  bit    exp_stall, obs_stall;

  function automatic int hist();
`ifdef PRED_GSHARE_EN
    return m_ghr;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    foreach (m_ctr[i]) m_ctr[i] = 1;
    m_q.delete();
    m_starve = 0; m_init_left = ENTRIES;
    m_pv = 0; m_pt = 0; m_ghr = 0;
  endtask

  // Apply one cycle of inputs (called at negedge), record the combinational
  // stall seen before the edge, advance the model, return at next negedge.
  task automatic step(input bit fr, input logic [31:0] pc, input bit tr,
                      input logic [31:0] tpc, input bit tres, input bit rd, input bit rs);
    bit running, frc, acc, enq;
    int gm, i;
    tent_t e;
    bus.Fetcher_Ready = fr; bus.PC = pc;
    bus.Train_Ready = tr; bus.Train_PC = tpc; bus.Train_Result = tres;
    rdy = rd; rst = rs;
    running = (m_init_left == 0);
    frc = running && (m_q.size() > 0) && (!fr || m_starve == STARVE_LIMIT);
    acc = running && fr && !frc;
    exp_stall = !running || (fr && frc);
    #1 obs_stall = bus.Lookup_Stall;
    @(posedge clk);
    if (!rs) model_reset();
    else if (rd) begin
      gm  = hist();
      enq = tr && (m_q.size() < TQ_DEPTH);
      if (!running) m_init_left--;
      if (frc) begin
        e = m_q.pop_front();
        i = (e.idx ^ gm) & IMASK;
        if (e.tk) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
        else      m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        m_ghr = ((m_ghr << 1) | int'(e.tk)) & IMASK;
        m_starve = 0; m_pv = 0;
      end else if (acc) begin
        m_pv = 1;
        m_pt = (m_ctr[(int'(pc >> 2) ^ gm) & IMASK] >= 2);
        m_starve = (m_q.size() > 0) ? m_starve + 1 : 0;
      end else begin
        m_pv = 0;
        if (running) m_starve = 0;
      end
      if (enq) m_q.push_back('{int'(tpc >> 2) & IMASK, tres});
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 32'h0, 0, 32'h0, 0, 1, 1);
  endtask

  // Reset, then run out the sweep; returns sweep length seen on Init_Busy.
  task automatic reset_and_sweep(output int n);
    step(0, 32'h0, 0, 32'h0, 0, 1, 0);
    n = 0;
    while (bus.Init_Busy === 1'b1 && n < 400) begin
      step(0, 32'h0, 0, 32'h0, 0, 1, 1);
      n++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int n;
    logic [31:0] pc;
    step(1, 32'h40, 0, 32'h0, 0, 1, 0);
    checks++; if (bus.Predict_Valid !== 1'b0) begin failures++; $display("FAIL reset_pv got=%b want=0", bus.Predict_Valid); end
    checks++; if (bus.Predict_Taken !== 1'b0) begin failures++; $display("FAIL reset_pt got=%b want=0", bus.Predict_Taken); end
    checks++; if (bus.Init_Busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b want=1", bus.Init_Busy); end
    checks++; if (bus.Train_Full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b want=0", bus.Train_Full); end
    checks++; if (bus.Lookup_Stall !== 1'b1) begin failures++; $display("FAIL reset_stall got=%b want=1", bus.Lookup_Stall); end
    n = 0;
    while (bus.Init_Busy === 1'b1 && n < 400) begin
      step(1, $urandom, 0, 32'h0, 0, 1, 1);
      checks++; if (obs_stall !== 1'b1) begin failures++; $display("FAIL init_stall cyc=%0d got=%b want=1", n, obs_stall); end
      n++;
    end
    checks++; if (n != ENTRIES) begin failures++; $display("FAIL sweep_len got=%0d want=%0d", n, ENTRIES); end
    pc = $urandom;
    step(1, pc, 0, 32'h0, 0, 1, 1);
    checks++; if (obs_stall !== 1'b0) begin failures++; $display("FAIL first_lookup_stall got=%b want=0", obs_stall); end
    checks++; if (bus.Predict_Valid !== 1'b1) begin failures++; $display("FAIL first_lookup_pv got=%b want=1", bus.Predict_Valid); end
    checks++; if (bus.Predict_Taken !== 1'b0) begin failures++; $display("FAIL first_lookup_pt pc=%h got=%b want=0", pc, bus.Predict_Taken); end
  endtask

  task automatic test_train_lookup();
    for (int k = 0; k < 3; k++) step(0, 32'h0, 1, 32'h100, 1, 1, 1);
    idle(2);
    step(1, 32'h100, 0, 32'h0, 0, 1, 1);
    checks++; if (bus.Predict_Valid !== 1'b1) begin failures++; $display("FAIL taken_pv got=%b want=1", bus.Predict_Valid); end
    checks++; if (bus.Predict_Taken !== m_pt) begin failures++; $display("FAIL taken_pt got=%b want=%b", bus.Predict_Taken, m_pt); end
`ifndef PRED_GSHARE_EN
    checks++; if (bus.Predict_Taken !== 1'b1) begin failures++; $display("FAIL taken_pt_const got=%b want=1", bus.Predict_Taken); end
`endif
    for (int k = 0; k < 2; k++) step(0, 32'h0, 1, 32'h100, 0, 1, 1);
    idle(2);
    step(1, 32'h100, 0, 32'h0, 0, 1, 1);
    checks++; if (bus.Predict_Taken !== m_pt) begin failures++; $display("FAIL nt_pt got=%b want=%b", bus.Predict_Taken, m_pt); end
`ifndef PRED_GSHARE_EN
    checks++; if (bus.Predict_Taken !== 1'b0) begin failures++; $display("FAIL nt_pt_const got=%b want=0", bus.Predict_Taken); end
`endif
  endtask

  task automatic test_starvation();
    idle(2);
    step(0, 32'h0, 1, $urandom, 1'($urandom), 1, 1);
    for (int k = 0; k < 5; k++) begin
      step(1, $urandom, 0, 32'h0, 0, 1, 1);
      checks++; if (obs_stall !== (k == 3)) begin failures++; $display("FAIL starve_stall cyc=%0d got=%b want=%b", k, obs_stall, (k == 3)); end
      checks++; if (bus.Predict_Valid !== (k != 3)) begin failures++; $display("FAIL starve_pv cyc=%0d got=%b want=%b", k, bus.Predict_Valid, (k != 3)); end
    end
  endtask

  task automatic test_back_to_back();
    int pops;
    idle(3);
    pops = 0;
    for (int k = 0; k < 5; k++) begin
      step(1, $urandom, 1, $urandom, 1'($urandom), 1, 1);
      if (obs_stall) pops++;
      checks++; if (bus.Train_Full !== (k == 3)) begin failures++; $display("FAIL b2b_full cyc=%0d got=%b want=%b", k, bus.Train_Full, (k == 3)); end
    end
    for (int k = 0; k < 30; k++) begin
      step(1, $urandom, 0, 32'h0, 0, 1, 1);
      if (obs_stall) pops++;
    end
    checks++; if (pops != TQ_DEPTH) begin failures++; $display("FAIL b2b_pops got=%0d want=%0d", pops, TQ_DEPTH); end
  endtask

  task automatic test_reset_mid_init();
    int n;
    step(0, 32'h0, 0, 32'h0, 0, 1, 0);
    idle(98);
    step(0, 32'h0, 1, $urandom, 1, 1, 1);
    step(0, 32'h0, 1, $urandom, 0, 1, 1);
    checks++; if (bus.Init_Busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b want=1", bus.Init_Busy); end
    reset_and_sweep(n);
    checks++; if (n != ENTRIES) begin failures++; $display("FAIL mid_sweep_len got=%0d want=%0d", n, ENTRIES); end
    checks++; if (bus.Train_Full !== 1'b0) begin failures++; $display("FAIL mid_full got=%b want=0", bus.Train_Full); end
    for (int k = 0; k < 5; k++) begin
      step(1, $urandom, 0, 32'h0, 0, 1, 1);
      checks++; if (obs_stall !== 1'b0) begin failures++; $display("FAIL mid_queue_discard cyc=%0d got=%b want=0", k, obs_stall); end
    end
  endtask

  task automatic test_gshare();
    int n;
    reset_and_sweep(n);
    step(0, 32'h0, 1, 32'h0, 1, 1, 1);
    idle(2);
    step(1, 32'h4, 0, 32'h0, 0, 1, 1);
    checks++; if (bus.Predict_Taken !== m_pt) begin failures++; $display("FAIL gshare_pt_model got=%b want=%b", bus.Predict_Taken, m_pt); end
`ifdef PRED_GSHARE_EN
    checks++; if (bus.Predict_Taken !== 1'b1) begin failures++; $display("FAIL gshare_pt got=%b want=1", bus.Predict_Taken); end
`else
    checks++; if (bus.Predict_Taken !== 1'b0) begin failures++; $display("FAIL plain_pt got=%b want=0", bus.Predict_Taken); end
`endif
  endtask

  task automatic test_random();
    bit rd, rs;
    logic [31:0] pc, tpc;
    for (int c = 0; c < 3000; c++) begin
      rd  = ($urandom_range(0, 9) != 0);
      rs  = ($urandom_range(0, 1499) != 0);
      pc  = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2);
      tpc = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2);
      step(1'($urandom), pc, 1'($urandom), tpc, 1'($urandom), rd, rs);
      if (rd) begin
        checks++; if (obs_stall !== exp_stall) begin failures++; $display("FAIL rnd_stall cyc=%0d got=%b want=%b", c, obs_stall, exp_stall); end
      end
      checks++; if (bus.Predict_Valid !== m_pv) begin failures++; $display("FAIL rnd_pv cyc=%0d got=%b want=%b", c, bus.Predict_Valid, m_pv); end
      checks++; if (bus.Predict_Taken !== m_pt) begin failures++; $display("FAIL rnd_pt cyc=%0d got=%b want=%b", c, bus.Predict_Taken, m_pt); end
      checks++; if (bus.Train_Full !== (m_q.size() == TQ_DEPTH)) begin failures++; $display("FAIL rnd_full cyc=%0d got=%b want=%b", c, bus.Train_Full, (m_q.size() == TQ_DEPTH)); end
      checks++; if (bus.Init_Busy !== (m_init_left > 0)) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%b want=%b", c, bus.Init_Busy, (m_init_left > 0)); end
    end
  endtask

  initial begin
    bus.Fetcher_Ready = 1'b0; bus.PC = '0;
    bus.Train_Ready = 1'b0; bus.Train_PC = '0; bus.Train_Result = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_train_lookup();
    test_starvation();
    test_back_to_back();
    test_reset_mid_init();
    test_gshare();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bht_scheduler.md
Name: bht_scheduler

Overview:
- Owns the branch history table (BHT) of 2-bit saturating counters used for conditional-branch direction prediction.
- Shares the table's single access slot per cycle between fetch-side lookups and RS-side training updates.
- Buffers training results in a queue, and prevents update starvation by stalling fetch when needed.
- Clears the table after reset with a sweep FSM; sits between Fetcher (lookup), RS (train) and the predictor's target logic.

Parameters:
IDX_W, 8, BHT index width; table has 2^IDX_W entries, index = PC[IDX_W+1:2]
TQ_DEPTH, 4, training queue depth; must be a power of 2
STARVE_LIMIT, 3, max consecutive lookup-won cycles while queue non-empty before an update is forced

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-low (rst==0 resets on posedge clk)
rdy  in  1  ready; when low every register holds
Fetcher_Ready  in  1  lookup request, held by Fetcher until accepted
PC  in  32  lookup PC
Predict_Valid  out  1  prediction for the previously accepted lookup is present
Predict_Taken  out  1  predicted direction (counter MSB)
Lookup_Stall  out  1  lookup not accepted this cycle (combinational)
Train_Ready  in  1  training result valid
Train_PC  in  32  PC of resolved branch
Train_Result  in  1  1 = taken
Train_Full  out  1  queue full; Train_Ready is ignored while high
Init_Busy  out  1  table clear sweep in progress

Behaviour:
- Reset (rst==0): FSM=INIT, init_idx=0, queue empty, starve_cnt=0. Outputs: Predict_Valid=0, Predict_Taken=0, Init_Busy=1, Train_Full=0, Lookup_Stall=1. Reset asserted mid-sweep or mid-operation restarts INIT from index 0 and discards queued entries.
- INIT: each cycle writes 2'b01 (weakly not-taken) to entry init_idx, then increments. After entry 2^IDX_W-1 the FSM enters RUN. Sweep takes exactly 2^IDX_W cycles with rdy high. Lookups stall during INIT. Queue still accepts enqueues during INIT.
- rdy low: all state frozen, including outputs and the queue; inputs are ignored.
- Queue: circular buffer with wrap-bit pointers. Train_Full = (count==TQ_DEPTH), taken from registered count.
  - Enqueue when Train_Ready && !Train_Full.
  - An entry enqueued in cycle N is dequeue-eligible from N+1.
  - Enqueue and dequeue in the same cycle are both legal; when full, the enqueue is refused even if a dequeue happens that cycle.
- RUN arbitration, one table access per cycle:
  - force = queue non-empty && (!Fetcher_Ready || starve_cnt==STARVE_LIMIT).
  - If force: update the head entry's counter; Taken saturates at 3, Not-taken saturates at 0. Pop the entry, set starve_cnt=0. Lookup_Stall=1 if Fetcher_Ready.
  - Else if Fetcher_Ready: lookup is accepted, Lookup_Stall=0. starve_cnt++ if queue non-empty, else starve_cnt=0.
- Lookup latency 1: lookup accepted in cycle N -> Predict_Valid=1 and Predict_Taken=ctr[idx][1] in N+1. Otherwise Predict_Valid=0 and Predict_Taken holds its value.
- Write-then-read: an update in cycle N is visible to a lookup in N+1 or later.
- Counter encoding: 0 SNT, 1 WNT, 2 WT, 3 ST.

Optional Feature:
PRED_GSHARE_EN
- Defined: adds an IDX_W-bit global history register (GHR), reset to 0.
  - Lookup index = PC[IDX_W+1:2] ^ GHR.
  - Update index = Train_PC[IDX_W+1:2] ^ GHR, using GHR before the shift.
  - Each update cycle shifts: GHR = {GHR[IDX_W-2:0], Train_Result}.
  - GHR frozen during INIT and when rdy is low.
- Undefined: no GHR; plain PC indexing.

Decomposition:
- constants.v gets: counter encodings (BHT_SNT/WNT/WT/ST), FSM state codes (BHT_INIT, BHT_RUN), and the reset value 2'b01.
- One sub-module, bht_train_fifo: parameterised queue with enqueue/dequeue, count and full flag.
- Table, arbitration, starvation counter and INIT FSM stay in bht_scheduler.

Test Plan:
- Reset, then hold Fetcher_Ready=1, IDX_W=8 -> Init_Busy=1 and Lookup_Stall=1 for 256 cycles. First accepted lookup of any PC returns Predict_Taken=0 one cycle later.
- Train PC=0x100 taken three times with Fetcher_Ready=0, then lookup 0x100 -> counter 01->10->11->11, Predict_Taken=1. Two not-taken trains -> counter 01, Predict_Taken=0.
- Fetcher_Ready held 1 with one queued entry, STARVE_LIMIT=3 -> 3 lookups accepted, 4th cycle Lookup_Stall=1 and the entry is popped, 5th cycle lookup accepted.
- Enqueue 5 entries back-to-back with Fetcher_Ready=1 (TQ_DEPTH=4) -> Train_Full=1 after the 4th, 5th entry dropped; only 4 pops ever occur.
- Pull rst low mid-INIT (index 100) with 2 queued entries -> queue empty, sweep restarts at 0 and lasts 256 cycles.
- With PRED_GSHARE_EN, train PC=0x0 taken, then look up PC=0x4 -> GHR=1, index 1^1=0, Predict_Taken reflects entry 0 (counter 10 -> 1).
